// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debouncer: FSM encoding, default filter
// length and the counter width helper.
package key_debounce_pulse_pkg;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  // $clog2 of the filter length, kept at least one bit wide so that a
  // one-cycle filter still has a legal counter vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_pulse_channel.sv
// One key channel: 2-flop synchronizer, press/release filter FSM with its
// stability counter, and registered flag/release/held outputs.
module key_channel
  import key_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic flag,
  output logic rel,
  output logic held
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  key_fsm_e         state_reg;
  key_fsm_e         state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             flag_reg;
  logic             flag_next;
  logic             rel_reg;
  logic             rel_next;
  logic             held_reg;
  logic             held_next;

  // Bring the asynchronous, active-low key into the clock domain; idle level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Filter FSM: the counter only runs while a level change is being qualified,
  // and stops at CNT_LAST so it can never wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    flag_next  = 1'b0;
    rel_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!sync2_reg) state_next = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (sync2_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DOWN;
          flag_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DOWN: begin
        if (sync2_reg) state_next = REL_FILT;
      end
      REL_FILT: begin
        if (!sync2_reg) begin
          state_next = DOWN;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          rel_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    held_next = (state_next == DOWN) || (state_next == REL_FILT);
  end

  // State, counter and all outputs are registered so nothing from key_raw reaches a port combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      flag_reg  <= 1'b0;
      rel_reg   <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      flag_reg  <= flag_next;
      rel_reg   <= rel_next;
      held_reg  <= held_next;
    end
  end

  assign flag = flag_reg;
  assign rel  = rel_reg;
  assign held = held_reg;

endmodule

// File: rtl/key_debounce_pulse.sv
// Multi-key debouncer: one fully independent key_channel per key bit.
// key_flag[0]/key_flag[1] feed the IIC controller's write/read requests.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_flag,
  output logic [N_KEYS-1:0] key_rel,
  output logic [N_KEYS-1:0] key_state
);

  // No arbitration between keys: simultaneous presses each pulse their own flag.
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_in[gi]),
        .flag   (key_flag[gi]),
        .rel    (key_rel[gi]),
        .held   (key_state[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: two instances (filter length 8 and 1) share
// the key stimulus. A run-length reference model predicts every press/release
// pulse into a queue; a monitor pops and compares whenever a DUT pulses.
module tb_key_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_in = 2'b11;
  logic [1:0] flag_a, rel_a, state_a;
  logic [1:0] flag_b, rel_b, state_b;

  key_debounce_pulse #(.N_KEYS(2), .DEBOUNCE_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_flag(flag_a), .key_rel(rel_a), .key_state(state_a)
  );

  key_debounce_pulse #(.N_KEYS(2), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_flag(flag_b), .key_rel(rel_b), .key_state(state_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int inst;
    int chan;
    bit is_rel;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dcyc[2] = '{8, 1};
  bit   m_held[2][2];
  int   m_run[2][2];
  bit [1:0] d1 = 2'b11;
  bit [1:0] d2 = 2'b11;

  // Reference model: the filter sees the raw key two clocks late; a level
  // opposite to the debounced one must be seen on DEBOUNCE_CYCLES+1
  // consecutive clocks before the debounced level flips and a pulse is due.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        m_held[i][c] = 1'b0;
        m_run[i][c]  = 0;
      end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        d1 = 2'b11;
        d2 = 2'b11;
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 2; c++) begin
            m_held[i][c] = 1'b0;
            m_run[i][c]  = 0;
          end
      end else begin
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 2; c++) begin
            if (!d2[c] == m_held[i][c]) begin
              m_run[i][c] = 0;
            end else begin
              m_run[i][c]++;
              if (m_run[i][c] == dcyc[i] + 1) begin
                ev_t e;
                m_held[i][c] = !m_held[i][c];
                m_run[i][c]  = 0;
                e.cyc = cyc; e.inst = i; e.chan = c; e.is_rel = !m_held[i][c];
                exp_q.push_back(e);
              end
            end
          end
        d2 = d1;
        d1 = key_in;
      end
    end
  end

  // Monitor: compare held levels every cycle and match every pulse against the queue.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) begin
          logic f, r, s;
          f = (i == 0) ? flag_a[c]  : flag_b[c];
          r = (i == 0) ? rel_a[c]   : rel_b[c];
          s = (i == 0) ? state_a[c] : state_b[c];
          checks++;
          if (s != m_held[i][c]) begin
            errors++;
            $display("FAIL key_state inst%0d ch%0d cyc%0d: got %0b expected %0b", i, c, cyc, s, m_held[i][c]);
          end
          checks++;
          if (f && r) begin
            errors++;
            $display("FAIL flag_and_rel inst%0d ch%0d cyc%0d: got both high expected at most one", i, c, cyc);
          end
          if (f || r) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse inst%0d ch%0d cyc%0d: got flag=%0b rel=%0b expected none", i, c, cyc, f, r);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.cyc != cyc || e.inst != i || e.chan != c || e.is_rel != r) begin
                errors++;
                $display("FAIL pulse inst%0d ch%0d cyc%0d rel=%0b: expected inst%0d ch%0d cyc%0d rel=%0b",
                         i, c, cyc, r, e.inst, e.chan, e.cyc, e.is_rel);
              end
            end
          end
        end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse cyc%0d: expected inst%0d ch%0d rel=%0b, got no pulse",
                 exp_q[0].cyc, exp_q[0].inst, exp_q[0].chan, exp_q[0].is_rel);
        void'(exp_q.pop_front());
      end
    end
  end

  // Wait (bounded) for the first key_flag of one channel; at = -1 on timeout.
  task automatic wait_flag(input int inst, input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((inst == 0) ? flag_a[ch] : flag_b[ch]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int t0;
    int at;
    int run_left[2];

    // Reset state
    repeat (3) @(negedge clk);
    check_int("reset_outputs", int'({flag_a, rel_a, state_a, flag_b, rel_b, state_b}), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean press on key 0
    key_in[0] = 1'b0; t0 = cyc;
    wait_flag(0, 0, 40, at);
    check_int("clean_press_latency", at - t0, 11);
    check_int("clean_press_state", int'(state_a[0]), 1);
    repeat (9) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (15) @(negedge clk);
    $display("txn clean_press: flag at +%0d", at - t0);

    // Bounce on key 1, then held low
    for (int j = 0; j < 10; j++) begin
      key_in[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) @(negedge clk);
    end
    key_in[1] = 1'b0; t0 = cyc;
    wait_flag(0, 1, 40, at);
    check_int("bounce_latency", at - t0, 11);
    repeat (10) @(negedge clk);
    key_in[1] = 1'b1;
    repeat (15) @(negedge clk);
    $display("txn bounce: flag at +%0d after last toggle", at - t0);

    // Release glitch on a held key 0
    key_in[0] = 1'b0;
    repeat (16) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    key_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_int("glitch_state_held", int'(state_a[0]), 1);
    key_in[0] = 1'b1;
    repeat (15) @(negedge clk);
    check_int("glitch_state_released", int'(state_a[0]), 0);
    $display("txn release_glitch: done");

    // Simultaneous press on both keys
    key_in = 2'b00; t0 = cyc;
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (flag_a != 2'b00) begin at = cyc; break; end
    end
    check_int("simul_latency", at - t0, 11);
    check_int("simul_flags", int'(flag_a), 3);
    @(negedge clk);
    check_int("simul_flags_next", int'(flag_a), 0);
    repeat (5) @(negedge clk);
    key_in = 2'b11;
    repeat (15) @(negedge clk);
    $display("txn simultaneous: done");

    // Reset during press filtering, key kept held
    key_in[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_int("outputs_in_reset", int'({flag_a, rel_a, state_a}), 0);
    end
    rst = 1'b0; t0 = cyc;
    wait_flag(0, 0, 40, at);
    check_int("reset_refilter_latency", at - t0, 11);
    repeat (5) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (15) @(negedge clk);
    $display("txn reset_mid_filter: flag at +%0d after reset release", at - t0);

    // One-cycle filter instance
    key_in[1] = 1'b0; t0 = cyc;
    wait_flag(1, 1, 20, at);
    check_int("d1_latency", at - t0, 4);
    repeat (15) @(negedge clk);
    key_in[1] = 1'b1;
    repeat (15) @(negedge clk);
    $display("txn d1_press: flag at +%0d", at - t0);

    // Random key activity with occasional resets
    run_left[0] = 0;
    run_left[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (run_left[c] == 0) begin
          key_in[c]   = 1'($urandom_range(0, 1));
          run_left[c] = $urandom_range(1, 14);
        end
        run_left[c]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    key_in = 2'b11;
    repeat (30) @(negedge clk);
    $display("txn random: 1500 cycles done");

    check_int("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 Parameter N_KEYS, default 2: number of independent key channels (bit 0 = write key, bit 1 = read key).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable-level count to confirm a press or release (20 ms at 50 MHz).
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port key_in, input, N_KEYS: raw board keys, asynchronous, active-low (0 = pressed).
REQ-006 Port key_flag, output, N_KEYS: one-cycle high pulse per confirmed press; drives the IIC controller's key_wr/key_rd.
REQ-007 Port key_rel, output, N_KEYS: one-cycle high pulse per confirmed release.
REQ-008 Port key_state, output, N_KEYS: debounced level, 1 = held.

Function
REQ-009 Each key_in bit SHALL pass through a 2-flop synchronizer, reset to 1 (released), before any other logic.
REQ-010 Each channel SHALL run an independent FSM: IDLE, PRESS_FILT, DOWN, REL_FILT.
REQ-011 IDLE: synchronized key = 0 -> PRESS_FILT, counter cleared; otherwise stay.
REQ-012 PRESS_FILT: counter increments each cycle key = 0; key = 1 at any count -> IDLE, counter cleared, no pulse.
REQ-013 PRESS_FILT: counter reaching DEBOUNCE_CYCLES-1 with key = 0 -> DOWN; key_flag high exactly one cycle, registered, coincident with entry into DOWN.
REQ-014 DOWN: key = 1 -> REL_FILT, counter cleared; key_state = 1 throughout DOWN and REL_FILT.
REQ-015 REL_FILT: key = 0 at any count -> DOWN, no pulse; counter reaching DEBOUNCE_CYCLES-1 with key = 1 -> IDLE, key_rel high one cycle.
REQ-016 Latency: key_flag asserts DEBOUNCE_CYCLES + 3 cycles after the raw falling edge of a clean press (2 sync + entry + count).
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap and SHALL hold 0 in IDLE and DOWN.
REQ-018 Channels SHALL be fully independent; simultaneous presses on both keys SHALL each produce its own key_flag, possibly in the same cycle; no priority arbitration in this block.
REQ-019 At most one key_flag pulse per channel between two key_rel pulses; key_flag and key_rel never both high on one channel.
REQ-020 DEBOUNCE_CYCLES = 1 SHALL be legal: confirmation on the first cycle the synchronized level is seen.

Reset
REQ-021 rst high at a clock edge SHALL put every FSM in IDLE, counters to 0, synchronizer flops to 1, key_flag = 0, key_rel = 0, key_state = 0.
REQ-022 Reset mid-filter or mid-hold SHALL discard progress with no pulse; a key still held after reset release SHALL be re-debounced and produce a fresh key_flag.

Structure
REQ-023 FSM state encoding constants (IDLE, PRESS_FILT, DOWN, REL_FILT) and the default DEBOUNCE_CYCLES SHALL live in the shared key package.
REQ-024 One sub-module, key_channel (synchronizer + FSM + counter for one bit), SHALL be instantiated N_KEYS times by generate.
REQ-025 All outputs SHALL be registered; no combinational path from key_in to any output.

Verification (DEBOUNCE_CYCLES = 8 for simulation)
REQ-026 Clean press: key_in[0] 1->0 held 20 cycles -> single key_flag[0] pulse exactly 11 cycles after edge; key_state[0] = 1 from that cycle.
REQ-027 Bounce: key_in[1] toggles every 3 cycles for 30 cycles then held 0 -> exactly one key_flag[1], 11 cycles after the last toggle.
REQ-028 Release glitch: held key goes 1 for 4 cycles then back to 0 -> no key_rel, key_state stays 1; a later 1 held 10 cycles -> one key_rel.
REQ-029 Simultaneous: both keys fall on the same cycle -> key_flag = 2'b11 for one cycle, key_flag = 0 on the following cycle.
REQ-030 Reset mid-PRESS_FILT (rst high on count 5, key held) -> no pulse during reset; after rst low, key_flag 11 cycles later; outputs 0 while rst high.
